// File: rtl/memory_module_pkg.sv
// Shared constants for the cached byte memory: one-hot FSM encoding, opcodes and cache geometry.
package memory_module_pkg;

    localparam int ST_IDLE      = 0;
    localparam int ST_DECODE    = 1;
    localparam int ST_IND_TAG   = 2;
    localparam int ST_IND_WB    = 3;
    localparam int ST_IND_FILL  = 4;
    localparam int ST_IND_FWAIT = 5;
    localparam int ST_TAG       = 6;
    localparam int ST_WB        = 7;
    localparam int ST_FILL      = 8;
    localparam int ST_FWAIT     = 9;
    localparam int ST_READ      = 10;
    localparam int ST_WRITE     = 11;
    localparam int ST_DONE      = 12;

    typedef enum logic [12:0] {
        S_IDLE      = 13'(1) << ST_IDLE,
        S_DECODE    = 13'(1) << ST_DECODE,
        S_IND_TAG   = 13'(1) << ST_IND_TAG,
        S_IND_WB    = 13'(1) << ST_IND_WB,
        S_IND_FILL  = 13'(1) << ST_IND_FILL,
        S_IND_FWAIT = 13'(1) << ST_IND_FWAIT,
        S_TAG       = 13'(1) << ST_TAG,
        S_WB        = 13'(1) << ST_WB,
        S_FILL      = 13'(1) << ST_FILL,
        S_FWAIT     = 13'(1) << ST_FWAIT,
        S_READ      = 13'(1) << ST_READ,
        S_WRITE     = 13'(1) << ST_WRITE,
        S_DONE      = 13'(1) << ST_DONE
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    localparam int INDEX_W = 3;
    localparam int TAG_W   = 5;

endpackage

// File: rtl/memory_ram.sv
// Main RAM: synchronous write, registered read, synchronous clear of every byte.
module memory_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/memory_module.sv
// Byte memory behind an 8-line direct-mapped write-back cache, with optional
// one-level indirect addressing through a pointer held in memory.
module memory_module
    import memory_module_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LINES  = 8
) (
    input  logic              clk,
    input  logic              clrRAM,
    input  logic              start,
    input  logic              isIndirect,
    input  logic [1:0]        cntrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataReady,
    output logic [12:0]       TEMPstateTEMP,
    output logic [1:0]        hitCleanTEMP
);

    state_t            state;
    logic [1:0]        op_q;
    logic              ind_q;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] din_q;

    logic [DATA_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic               hit;
    logic               victim_dirty;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_rdata;

    assign idx          = ea[INDEX_W-1:0];
    assign tg           = ea[ADDR_W-1:INDEX_W];
    assign hit          = valid[idx] && (tag_q[idx] == tg);
    assign victim_dirty = valid[idx] && dirty[idx];
    assign ram_we       = state[ST_WB] | state[ST_IND_WB];
    assign TEMPstateTEMP = state;

    // Read address is the lookup address; the FILL-cycle sample lands in FWAIT.
    memory_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .clr   (clrRAM),
        .we    (ram_we),
        .waddr ({tag_q[idx], idx}),
        .wdata (data_q[idx]),
        .raddr (ea),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (clrRAM) begin
            state        <= S_IDLE;
            valid        <= '0;
            dirty        <= '0;
            dataOut      <= '0;
            dataReady    <= 1'b0;
            hitCleanTEMP <= 2'b00;
        end else begin
            dataReady <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && (cntrl == OP_READ || cntrl == OP_WRITE)) begin
                        op_q  <= cntrl;
                        ind_q <= isIndirect;
                        ea    <= addr;
                        din_q <= dataIn;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= ind_q ? S_IND_TAG : S_TAG;
                S_IND_TAG, S_TAG: begin
                    // clean bit means "no eviction write-back was needed"
                    hitCleanTEMP <= {hit, !(!hit && victim_dirty)};
                    if (hit) begin
                        if (state == S_IND_TAG) begin
                            ea    <= data_q[idx];
                            state <= S_TAG;
                        end else begin
                            state <= (op_q == OP_READ) ? S_READ : S_WRITE;
                        end
                    end else if (victim_dirty) begin
                        state <= (state == S_IND_TAG) ? S_IND_WB : S_WB;
                    end else begin
                        state <= (state == S_IND_TAG) ? S_IND_FILL : S_FILL;
                    end
                end
                S_IND_WB: begin
                    dirty[idx] <= 1'b0;
                    state      <= S_IND_FILL;
                end
                S_WB: begin
                    dirty[idx] <= 1'b0;
                    state      <= S_FILL;
                end
                S_IND_FILL: state <= S_IND_FWAIT;
                S_FILL:     state <= S_FWAIT;
                S_IND_FWAIT, S_FWAIT: begin
                    data_q[idx] <= ram_rdata;
                    tag_q[idx]  <= tg;
                    valid[idx]  <= 1'b1;
                    dirty[idx]  <= 1'b0;
                    if (state == S_IND_FWAIT) begin
                        ea    <= ram_rdata;
                        state <= S_TAG;
                    end else begin
                        state <= (op_q == OP_READ) ? S_READ : S_WRITE;
                    end
                end
                S_READ: begin
                    dataOut   <= data_q[idx];
                    dataReady <= 1'b1;
                    state     <= S_DONE;
                end
                S_WRITE: begin
                    data_q[idx] <= din_q;
                    dirty[idx]  <= 1'b1;
                    dataReady   <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_module.sv
// Directed bench for memory_module: latency, hit/clean status, write-back and indirect paths.
module tb_memory_module;

    logic       clk = 1'b0;
    logic       clrRAM;
    logic       start;
    logic       isIndirect;
    logic [1:0] cntrl;
    logic [7:0] addr;
    logic [7:0] dataIn;
    logic [7:0] dataOut;
    logic       dataReady;
    logic [12:0] TEMPstateTEMP;
    logic [1:0] hitCleanTEMP;

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] M_IDLE  = 13'h0001;
    localparam logic [12:0] M_WB    = 13'h0080;
    localparam logic [12:0] M_FILL  = 13'h0100;
    localparam logic [12:0] M_FWAIT = 13'h0200;

    memory_module dut (
        .clk           (clk),
        .clrRAM        (clrRAM),
        .start         (start),
        .isIndirect    (isIndirect),
        .cntrl         (cntrl),
        .addr          (addr),
        .dataIn        (dataIn),
        .dataOut       (dataOut),
        .dataReady     (dataReady),
        .TEMPstateTEMP (TEMPstateTEMP),
        .hitCleanTEMP  (hitCleanTEMP)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one operation from IDLE and returns once the DUT is back in IDLE.
    task automatic run_op(input logic [1:0] op, input logic ind, input logic [7:0] a,
                          input logic [7:0] d, output int edges, output logic [12:0] seen);
        cntrl = op; isIndirect = ind; addr = a; dataIn = d; start = 1'b1;
        edges = 0; seen = '0;
        do begin
            @(posedge clk); #1;
            edges++;
            start = 1'b0;
            seen |= TEMPstateTEMP;
        end while (!dataReady && edges < 60);
        cntrl = 2'b00;
        if (!dataReady) check_val("timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        check_val("ready_pulse", {31'd0, dataReady}, 32'd0);
    endtask

    int          e;
    logic [12:0] s;

    initial begin
        clrRAM = 1'b1; start = 1'b0; isIndirect = 1'b0; cntrl = 2'b00; addr = '0; dataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_state", TEMPstateTEMP, M_IDLE);
        check_val("rst_dout", dataOut, 8'h00);
        check_val("rst_rdy", dataReady, 1'b0);
        check_val("rst_hc", hitCleanTEMP, 2'b00);
        clrRAM = 1'b0;

        // clean miss
        run_op(2'b01, 1'b0, 8'h25, 8'h00, e, s);
        check_val("rd25_hc", hitCleanTEMP, 2'b01);
        check_val("rd25_edges", e, 6);
        check_val("rd25_fill", s & (M_FILL | M_FWAIT), M_FILL | M_FWAIT);
        check_val("rd25_data", dataOut, 8'h00);

        // write hit then read hit
        run_op(2'b10, 1'b0, 8'h25, 8'hA5, e, s);
        check_val("wr25_hc", hitCleanTEMP, 2'b11);
        check_val("wr25_dout_hold", dataOut, 8'h00);
        run_op(2'b01, 1'b0, 8'h25, 8'h00, e, s);
        check_val("rd25b_hc", hitCleanTEMP, 2'b11);
        check_val("rd25b_edges", e, 4);
        check_val("rd25b_data", dataOut, 8'hA5);

        // dirty victim on index 5
        run_op(2'b10, 1'b0, 8'h05, 8'h11, e, s);
        check_val("wr05_hc", hitCleanTEMP, 2'b00);
        check_val("wr05_wb", s & M_WB, M_WB);
        check_val("wr05_edges", e, 7);
        run_op(2'b01, 1'b0, 8'h25, 8'h00, e, s);
        check_val("rd25c_data", dataOut, 8'hA5);
        check_val("rd25c_hc", hitCleanTEMP, 2'b00);
        run_op(2'b01, 1'b0, 8'h05, 8'h00, e, s);
        check_val("rd05_data", dataOut, 8'h11);

        // indirect access through pointer at 0x10
        run_op(2'b10, 1'b0, 8'h10, 8'h40, e, s);
        run_op(2'b10, 1'b0, 8'h40, 8'h77, e, s);
        run_op(2'b01, 1'b1, 8'h10, 8'h00, e, s);
        check_val("ind_rd_data", dataOut, 8'h77);
        run_op(2'b10, 1'b1, 8'h10, 8'h3C, e, s);
        run_op(2'b01, 1'b0, 8'h40, 8'h00, e, s);
        check_val("rd40_data", dataOut, 8'h3C);
        check_val("rd40_hc", hitCleanTEMP, 2'b11);

        // no-op opcodes leave the DUT idle
        start = 1'b1; addr = 8'h40; dataIn = 8'hEE;
        for (int k = 0; k < 8; k++) begin
            cntrl = (k < 4) ? 2'b00 : 2'b11;
            @(posedge clk); #1;
            check_val("noop_state", TEMPstateTEMP, M_IDLE);
            check_val("noop_rdy", dataReady, 1'b0);
        end
        start = 1'b0; cntrl = 2'b00;
        check_val("noop_hc", hitCleanTEMP, 2'b11);
        run_op(2'b01, 1'b0, 8'h40, 8'h00, e, s);
        check_val("noop_rd_edges", e, 4);
        check_val("noop_rd_data", dataOut, 8'h3C);

        // reset in the middle of a fill
        cntrl = 2'b01; isIndirect = 1'b0; addr = 8'h33; start = 1'b1;
        e = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            e++;
        end while (TEMPstateTEMP !== M_FWAIT && e < 30);
        check_val("reach_fwait", TEMPstateTEMP, M_FWAIT);
        clrRAM = 1'b1;
        @(posedge clk); #1;
        clrRAM = 1'b0; cntrl = 2'b00;
        check_val("clr_state", TEMPstateTEMP, M_IDLE);
        check_val("clr_rdy", dataReady, 1'b0);
        check_val("clr_dout", dataOut, 8'h00);
        run_op(2'b01, 1'b0, 8'h40, 8'h00, e, s);
        check_val("clr_rd40", dataOut, 8'h00);
        check_val("clr_rd40_hc", hitCleanTEMP, 2'b01);
        run_op(2'b01, 1'b0, 8'h25, 8'h00, e, s);
        check_val("clr_rd25", dataOut, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
